// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter shared types: FU result and CDB broadcast packets.
// Global sizing defines live here so every CDB file sees one value.
`ifndef NUM_FU
`define NUM_FU 4
`endif
`ifndef CDB_BUF_DEPTH
`define CDB_BUF_DEPTH 2
`endif
`ifndef ROB_SIZE
`define ROB_SIZE 32
`endif

package cdb_arbiter_pkg;

   localparam int SYS_XLEN = 32;
   localparam int SYS_TW   = $clog2(`ROB_SIZE);

   typedef struct packed {
      logic                valid;
      logic [SYS_TW-1:0]   Tag;
      logic [SYS_XLEN-1:0] Value;
      logic                take_branch;
      logic [SYS_XLEN-1:0] NPC;
   } FU_RESULT_PACKET;

   typedef struct packed {
      logic                valid;
      logic [SYS_TW-1:0]   Tag;
      logic [SYS_XLEN-1:0] Value;
      logic                take_branch;
      logic [SYS_XLEN-1:0] NPC;
   } CDB_PACKET;

   function automatic int rr_inc(input int idx, input int n);
      return (idx == n - 1) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Completion-bus bundle between functional units and the CDB arbiter.
// master = arbiter side, slave = functional-unit / consumer side.
interface cdb_arbiter_if #(
   parameter int NUM_FU = `NUM_FU
);
   import cdb_arbiter_pkg::*;

   FU_RESULT_PACKET [NUM_FU-1:0] fu_result_in;
   logic [NUM_FU-1:0]            fu_ready;
   CDB_PACKET                    cdb_packet_out;
   logic                         cdb_busy;

   modport master (
      input  fu_result_in,
      output fu_ready,
      output cdb_packet_out,
      output cdb_busy
   );

   modport slave (
      output fu_result_in,
      input  fu_ready,
      input  cdb_packet_out,
      input  cdb_busy
   );

endinterface

// File: rtl/cdb_fu_fifo.sv
// Per-FU result buffer: small FIFO with flush, count and full/empty.
// Full blocks a push even if the same cycle pops.
module cdb_fu_fifo
   import cdb_arbiter_pkg::*;
#(
   parameter int BUF_DEPTH = `CDB_BUF_DEPTH,
   localparam int PW = $clog2(BUF_DEPTH),
   localparam int CW = PW + 1
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            flush,
   input  logic            push,
   input  logic            pop,
   input  FU_RESULT_PACKET din,
   output FU_RESULT_PACKET head,
   output logic [CW-1:0]   count,
   output logic            full,
   output logic            empty
);

   FU_RESULT_PACKET mem [BUF_DEPTH];
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic            do_push;
   logic            do_pop;

   assign full    = (count == CW'(BUF_DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
         unique case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: count gates every read of it.
   always_ff @(posedge clock) begin
      if (do_push && !flush) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/cdb_arbiter.sv
// Complete stage: buffers FU results and broadcasts one per cycle
// on the CDB using round-robin selection across FU buffers.
module cdb_arbiter
   import cdb_arbiter_pkg::*;
#(
   parameter int NUM_FU    = `NUM_FU,
   parameter int BUF_DEPTH = `CDB_BUF_DEPTH,
   parameter int XLEN      = 32,
   parameter int ROB_SIZE  = `ROB_SIZE
) (
   input logic          clock,
   input logic          reset,
   input logic          squash_signal,
   cdb_arbiter_if.master bus
);

   localparam int RW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
   localparam int CW = $clog2(BUF_DEPTH) + 1;

   if (XLEN != SYS_XLEN || $clog2(ROB_SIZE) != SYS_TW) begin : g_bad_cfg
      $error("cdb_arbiter widths disagree with cdb_arbiter_pkg");
   end

   FU_RESULT_PACKET   head  [NUM_FU];
   logic [CW-1:0]     count [NUM_FU];
   logic [NUM_FU-1:0] full;
   logic [NUM_FU-1:0] empty;
   logic [NUM_FU-1:0] pop;

   logic [RW-1:0]     rr_ptr;
   logic              win_found;
   logic [RW-1:0]     win_idx;
   int                idx;
   FU_RESULT_PACKET   win_pkt;
   CDB_PACKET         cdb_q;
   logic              busy;

   for (genvar i = 0; i < NUM_FU; i++) begin : g_fifo
      cdb_fu_fifo #(
         .BUF_DEPTH(BUF_DEPTH)
      ) u_fifo (
         .clock (clock),
         .reset (reset),
         .flush (squash_signal),
         .push  (bus.fu_result_in[i].valid),
         .pop   (pop[i]),
         .din   (bus.fu_result_in[i]),
         .head  (head[i]),
         .count (count[i]),
         .full  (full[i]),
         .empty (empty[i])
      );
   end

   // Scan from rr_ptr; the first non-empty buffer wins.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      idx       = 0;
      for (int k = 0; k < NUM_FU; k++) begin
         idx = (int'(rr_ptr) + k) % NUM_FU;
         if (!win_found && !empty[idx]) begin
            win_found = 1'b1;
            win_idx   = RW'(idx);
         end
      end
   end

   always_comb begin
      pop = '0;
      if (win_found) pop[win_idx] = 1'b1;
   end

   assign win_pkt = head[win_idx];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cdb_q  <= '0;
         rr_ptr <= '0;
      end else if (squash_signal) begin
         cdb_q.valid <= 1'b0;
         rr_ptr      <= '0;
      end else if (win_found) begin
         cdb_q.valid       <= 1'b1;
         cdb_q.Tag         <= win_pkt.Tag;
         cdb_q.Value       <= win_pkt.Value;
         cdb_q.take_branch <= win_pkt.take_branch;
         cdb_q.NPC         <= win_pkt.NPC;
         rr_ptr            <= RW'(rr_inc(int'(win_idx), NUM_FU));
      end else begin
         cdb_q.valid <= 1'b0;
      end
   end

   always_comb begin
      busy = 1'b0;
      for (int i = 0; i < NUM_FU; i++) begin
         busy = busy | (count[i] != '0);
      end
   end

   assign bus.fu_ready       = ~full;
   assign bus.cdb_packet_out = cdb_q;
   assign bus.cdb_busy       = busy;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: vector table plus corner sequences.
module tb_cdb_arbiter;
   import cdb_arbiter_pkg::*;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic squash_signal = 1'b0;

   always #5 clock = ~clock;

   cdb_arbiter_if #(.NUM_FU(4)) bus ();

   cdb_arbiter #(
      .NUM_FU(4), .BUF_DEPTH(2), .XLEN(32), .ROB_SIZE(32)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .squash_signal (squash_signal),
      .bus           (bus.master)
   );

   typedef struct {
      logic [3:0]      push;
      logic [3:0][4:0] tags;
      logic [31:0]     val;
      logic            e_valid;
      logic [4:0]      e_tag;
      logic [31:0]     e_val;
      logic [3:0]      e_ready;
      logic            e_busy;
   } vec_t;

   vec_t vecs [17];
   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   function automatic logic [3:0][4:0] T(input int a, b, c, d);
      return {5'(d), 5'(c), 5'(b), 5'(a)};
   endfunction

   task automatic drive(input logic [3:0] m, input logic [3:0][4:0] tags,
                        input logic [31:0] v);
      for (int i = 0; i < 4; i++) begin
         bus.fu_result_in[i].valid       = m[i];
         bus.fu_result_in[i].Tag         = tags[i];
         bus.fu_result_in[i].Value       = v;
         bus.fu_result_in[i].take_branch = tags[i][0];
         bus.fu_result_in[i].NPC         = {25'b0, tags[i], 2'b00};
      end
   endtask

   task automatic idle();
      drive(4'b0, T(0, 0, 0, 0), 32'h0);
   endtask

   // Pushing into a full buffer is a protocol violation.
   always @(posedge clock) begin
      if (!reset) begin
         for (int i = 0; i < 4; i++) begin
            if (bus.fu_result_in[i].valid && !bus.fu_ready[i]) begin
               errors++;
               $display("FAIL protocol fu%0d: valid without ready", i);
            end
         end
      end
   end

   initial begin
      int sent, got, c0, c3, r0, r3, prev, src;
      logic [3:0] m;

      vecs[0]  = '{4'b0100, T(0,0,5,0),     32'hDEADBEEF, 1'b0, 5'd0,  32'h0,        4'hF,    1'b1};
      vecs[1]  = '{4'b0000, T(0,0,0,0),     32'h0,        1'b1, 5'd5,  32'hDEADBEEF, 4'hF,    1'b0};
      vecs[2]  = '{4'b1000, T(0,0,0,7),     32'h33,       1'b0, 5'd5,  32'hDEADBEEF, 4'hF,    1'b1};
      vecs[3]  = '{4'b0000, T(0,0,0,0),     32'h0,        1'b1, 5'd7,  32'h33,       4'hF,    1'b0};
      vecs[4]  = '{4'b1111, T(10,11,12,13), 32'h12345678, 1'b0, 5'd7,  32'h33,       4'hF,    1'b1};
      vecs[5]  = '{4'b0000, T(0,0,0,0),     32'h0,        1'b1, 5'd10, 32'h12345678, 4'hF,    1'b1};
      vecs[6]  = '{4'b0000, T(0,0,0,0),     32'h0,        1'b1, 5'd11, 32'h12345678, 4'hF,    1'b1};
      vecs[7]  = '{4'b0000, T(0,0,0,0),     32'h0,        1'b1, 5'd12, 32'h12345678, 4'hF,    1'b1};
      vecs[8]  = '{4'b0000, T(0,0,0,0),     32'h0,        1'b1, 5'd13, 32'h12345678, 4'hF,    1'b0};
      vecs[9]  = '{4'b0000, T(0,0,0,0),     32'h0,        1'b0, 5'd13, 32'h12345678, 4'hF,    1'b0};
      vecs[10] = '{4'b0011, T(20,21,0,0),   32'hCAFE0000, 1'b0, 5'd13, 32'h12345678, 4'hF,    1'b1};
      vecs[11] = '{4'b0011, T(22,23,0,0),   32'hCAFE0001, 1'b1, 5'd20, 32'hCAFE0000, 4'b1101, 1'b1};
      vecs[12] = '{4'b0001, T(24,0,0,0),    32'hCAFE0002, 1'b1, 5'd21, 32'hCAFE0000, 4'b1110, 1'b1};
      vecs[13] = '{4'b0000, T(0,0,0,0),     32'h0,        1'b1, 5'd22, 32'hCAFE0001, 4'hF,    1'b1};
      vecs[14] = '{4'b0000, T(0,0,0,0),     32'h0,        1'b1, 5'd23, 32'hCAFE0001, 4'hF,    1'b1};
      vecs[15] = '{4'b0000, T(0,0,0,0),     32'h0,        1'b1, 5'd24, 32'hCAFE0002, 4'hF,    1'b0};
      vecs[16] = '{4'b0000, T(0,0,0,0),     32'h0,        1'b0, 5'd24, 32'hCAFE0002, 4'hF,    1'b0};

      idle();
      #1;
      chk("reset valid", 64'(bus.cdb_packet_out.valid), 64'd0);
      chk("reset tag",   64'(bus.cdb_packet_out.Tag),   64'd0);
      chk("reset value", 64'(bus.cdb_packet_out.Value), 64'd0);
      chk("reset npc",   64'(bus.cdb_packet_out.NPC),   64'd0);
      chk("reset busy",  64'(bus.cdb_busy),             64'd0);
      chk("reset ready", 64'(bus.fu_ready),             64'hF);
      @(negedge clock);
      reset = 1'b0;

      for (int v = 0; v < 17; v++) begin
         drive(vecs[v].push, vecs[v].tags, vecs[v].val);
         step();
         chk($sformatf("v%0d valid", v), 64'(bus.cdb_packet_out.valid), 64'(vecs[v].e_valid));
         chk($sformatf("v%0d tag", v),   64'(bus.cdb_packet_out.Tag),   64'(vecs[v].e_tag));
         chk($sformatf("v%0d value", v), 64'(bus.cdb_packet_out.Value), 64'(vecs[v].e_val));
         chk($sformatf("v%0d br", v),    64'(bus.cdb_packet_out.take_branch), 64'(vecs[v].e_tag[0]));
         chk($sformatf("v%0d npc", v),   64'(bus.cdb_packet_out.NPC),   64'({vecs[v].e_tag, 2'b00}));
         chk($sformatf("v%0d ready", v), 64'(bus.fu_ready),             64'(vecs[v].e_ready));
         chk($sformatf("v%0d busy", v),  64'(bus.cdb_busy),             64'(vecs[v].e_busy));
      end
      idle();

      // FU1 streams alone: one broadcast per cycle, in order, never full.
      sent = 0;
      for (int c = 0; c < 14; c++) begin
         if (sent < 10 && bus.fu_ready[1]) begin
            drive(4'b0010, T(0, sent, 0, 0), 32'h100 + 32'(sent));
            sent++;
         end else begin
            idle();
         end
         step();
         chk($sformatf("stream c%0d valid", c), 64'(bus.cdb_packet_out.valid),
             64'(c >= 1 && c <= 10));
         if (c >= 1 && c <= 10)
            chk($sformatf("stream c%0d tag", c), 64'(bus.cdb_packet_out.Tag), 64'(c - 1));
         chk($sformatf("stream c%0d ready1", c), 64'(bus.fu_ready[1]), 64'd1);
      end
      chk("stream pushes", 64'(sent), 64'd10);

      // FU0 and FU3 saturated: broadcasts alternate, nothing lost.
      c0 = 0; c3 = 0; r0 = 0; r3 = 0; prev = -1;
      for (int c = 0; c < 16; c++) begin
         m = 4'b0;
         if (c < 8 && bus.fu_ready[0]) m[0] = 1'b1;
         if (c < 8 && bus.fu_ready[3]) m[3] = 1'b1;
         drive(m, T(c0, 0, 0, 16 + c3), 32'hAB);
         if (m[0]) c0++;
         if (m[3]) c3++;
         step();
         if (bus.cdb_packet_out.valid) begin
            src = int'(bus.cdb_packet_out.Tag[4]);
            if (prev != -1)
               chk($sformatf("sat c%0d alternate", c), 64'(src != prev), 64'd1);
            if (src == 0) begin
               chk($sformatf("sat c%0d fu0 tag", c), 64'(bus.cdb_packet_out.Tag), 64'(r0));
               r0++;
            end else begin
               chk($sformatf("sat c%0d fu3 tag", c), 64'(bus.cdb_packet_out.Tag), 64'(16 + r3));
               r3++;
            end
            prev = src;
         end
      end
      idle();
      chk("sat fu0 count", 64'(r0), 64'(c0));
      chk("sat fu3 count", 64'(r3), 64'(c3));
      chk("sat total", 64'(r0 + r3), 64'd10);

      // Squash with three results buffered.
      drive(4'b1111, T(1, 2, 3, 4), 32'h55);
      step();
      idle();
      step();
      chk("sq pre valid", 64'(bus.cdb_packet_out.valid), 64'd1);
      chk("sq pre tag",   64'(bus.cdb_packet_out.Tag),   64'd2);
      squash_signal = 1'b1;
      drive(4'b1000, T(0, 0, 0, 30), 32'h99);
      step();
      squash_signal = 1'b0;
      idle();
      chk("sq valid", 64'(bus.cdb_packet_out.valid), 64'd0);
      chk("sq tag hold", 64'(bus.cdb_packet_out.Tag), 64'd2);
      chk("sq busy",  64'(bus.cdb_busy),             64'd0);
      chk("sq ready", 64'(bus.fu_ready),             64'hF);
      for (int c = 0; c < 6; c++) begin
         step();
         chk($sformatf("sq after c%0d valid", c), 64'(bus.cdb_packet_out.valid), 64'd0);
      end

      // Asynchronous reset between edges mid-burst.
      drive(4'b1111, T(11, 12, 13, 14), 32'h77);
      step();
      idle();
      step();
      chk("ar pre valid", 64'(bus.cdb_packet_out.valid), 64'd1);
      chk("ar pre tag",   64'(bus.cdb_packet_out.Tag),   64'd11);
      #2;
      reset = 1'b1;
      #1;
      chk("ar valid", 64'(bus.cdb_packet_out.valid), 64'd0);
      chk("ar tag",   64'(bus.cdb_packet_out.Tag),   64'd0);
      chk("ar value", 64'(bus.cdb_packet_out.Value), 64'd0);
      chk("ar busy",  64'(bus.cdb_busy),             64'd0);
      chk("ar ready", 64'(bus.fu_ready),             64'hF);
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
      for (int c = 0; c < 6; c++) begin
         step();
         chk($sformatf("ar after c%0d valid", c), 64'(bus.cdb_packet_out.valid), 64'd0);
         chk($sformatf("ar after c%0d busy", c),  64'(bus.cdb_busy),             64'd0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
